// File: rtl/udp_tx_framer_pkg.sv
// Shared constants, state encoding and elaboration-time helpers for the UDP transmit framer.
package udp_tx_framer_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_ETH, S_IP, S_UDP, S_PAY, S_FCS, S_IFG
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    localparam int PRE_LEN     = 8;
    localparam int ETH_HDR_LEN = 14;
    localparam int IP_HDR_LEN  = 20;
    localparam int UDP_HDR_LEN = 8;
    localparam int FCS_LEN     = 4;
    localparam int MAX_PAYLOAD = 1472;
    localparam int PAY_CW      = $clog2(MAX_PAYLOAD + 1);

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Sum of the IPv4 header words that never change; ID and checksum words are excluded.
    function automatic logic [31:0] ip_csum_const(input logic [15:0] tot_len,
                                                  input logic [31:0] src,
                                                  input logic [31:0] dst);
        return 32'h4500 + 32'(tot_len) + 32'h4000 + 32'({8'h40, IP_PROTO_UDP})
             + 32'(src[31:16]) + 32'(src[15:0]) + 32'(dst[31:16]) + 32'(dst[15:0]);
    endfunction

endpackage

// File: rtl/udp_tx_framer_crc32_d8.sv
// Byte-parallel Ethernet CRC-32 (reflected); crc holds the raw register, caller inverts for the FCS.
module crc32_d8
    import udp_tx_framer_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  d,
    output logic [31:0] crc
);

    localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ POLY_R) : (r >> 1);
        return r;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     crc <= '1;
        else if (init) crc <= '1;
        else if (en)   crc <= crc_step(crc, d);
    end

endmodule

// File: rtl/udp_tx_framer.sv
// Ethernet II / IPv4 / UDP frame generator: pulls payload bytes from the send buffer and emits a
// one-byte-per-cycle frame with preamble, headers, IPv4 checksum, FCS and inter-frame gap.
module udp_tx_framer
    import udp_tx_framer_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC   = 48'h3C_2B_1A_09_4D_5E,
    parameter logic [31:0] LOCAL_IP    = 32'hC0_A8_01_6E,
    parameter logic [15:0] LOCAL_PORT  = 16'hF0F0,
    parameter logic [47:0] DEST_MAC    = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] DEST_IP     = 32'hC0_A8_01_69,
    parameter logic [15:0] DEST_PORT   = 16'hA0A0,
    parameter int          PAYLOAD_LEN = 1024,
    parameter int          IFG_LEN     = 12
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pkt_avail,
    output logic        fifo_rd_en,
    input  logic [7:0]  fifo_rd_data,
    input  logic        fifo_rd_empty,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic [15:0] pkt_cnt,
    output logic        underflow
);

    localparam int CW = ($clog2(IFG_LEN + 1) > PAY_CW) ? $clog2(IFG_LEN + 1) : PAY_CW;
    localparam logic [15:0]  TOT_LEN    = 16'(IP_HDR_LEN + UDP_HDR_LEN + PAYLOAD_LEN);
    localparam logic [15:0]  UDP_LEN    = 16'(UDP_HDR_LEN + PAYLOAD_LEN);
    localparam logic [31:0]  CSUM_CONST = ip_csum_const(TOT_LEN, LOCAL_IP, DEST_IP);
    localparam logic [111:0] ETH_HDR    = {DEST_MAC, LOCAL_MAC, ETHERTYPE_IPV4};
    localparam logic [63:0]  UDP_HDR    = {LOCAL_PORT, DEST_PORT, UDP_LEN, 16'h0000};

    state_t         state, nxt;
    logic [CW-1:0]  idx, last_idx;
    logic [7:0]     nb;
    logic [15:0]    pkt_id, ip_csum;
    logic [31:0]    csum_acc, crc;
    logic [159:0]   ip_hdr;
    logic           rd_pend, rd_window, crc_en, crc_init;

    assign ip_hdr = {8'h45, 8'h00, TOT_LEN, pkt_id, 16'h4000, 8'h40, IP_PROTO_UDP,
                     ip_csum, LOCAL_IP, DEST_IP};

    // The sequencer position (state, idx) names the byte that goes onto tx_data at the next edge,
    // so a payload byte is fetched while the sequencer sits one position earlier.
    assign rd_window  = (state == S_UDP && idx == CW'(UDP_HDR_LEN - 1)) ||
                        (state == S_PAY && idx <  CW'(PAYLOAD_LEN - 1));
    assign fifo_rd_en = rd_window & ~fifo_rd_empty;
    assign crc_init   = (state == S_PRE);
    assign crc_en     = (state == S_ETH) || (state == S_IP) || (state == S_UDP) || (state == S_PAY);

    always_comb begin
        nb       = 8'h00;
        last_idx = '0;
        nxt      = S_IFG;
        case (state)
            S_PRE: begin
                nb       = (idx == CW'(PRE_LEN - 1)) ? SFD_BYTE : PREAMBLE_BYTE;
                last_idx = CW'(PRE_LEN - 1);
                nxt      = S_ETH;
            end
            S_ETH: begin
                nb       = 8'(ETH_HDR >> (8 * (ETH_HDR_LEN - 1 - int'(idx))));
                last_idx = CW'(ETH_HDR_LEN - 1);
                nxt      = S_IP;
            end
            S_IP: begin
                nb       = 8'(ip_hdr >> (8 * (IP_HDR_LEN - 1 - int'(idx))));
                last_idx = CW'(IP_HDR_LEN - 1);
                nxt      = S_UDP;
            end
            S_UDP: begin
                nb       = 8'(UDP_HDR >> (8 * (UDP_HDR_LEN - 1 - int'(idx))));
                last_idx = CW'(UDP_HDR_LEN - 1);
                nxt      = S_PAY;
            end
            S_PAY: begin
                nb       = rd_pend ? fifo_rd_data : 8'h00;
                last_idx = CW'(PAYLOAD_LEN - 1);
                nxt      = S_FCS;
            end
            S_FCS: begin
                nb       = ~8'(crc >> (8 * int'(idx)));
                last_idx = CW'(FCS_LEN - 1);
                nxt      = S_IFG;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            idx       <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
            pkt_cnt   <= 16'h0000;
            pkt_id    <= 16'h0000;
            underflow <= 1'b0;
            rd_pend   <= 1'b0;
            csum_acc  <= 32'h0;
            ip_csum   <= 16'h0;
        end else begin
            rd_pend  <= fifo_rd_en;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            idx      <= idx + CW'(1);
            if (rd_window && fifo_rd_empty) underflow <= 1'b1;
            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (pkt_avail) begin
                        state    <= S_PRE;
                        idx      <= CW'(1);
                        busy     <= 1'b1;
                        pkt_id   <= pkt_cnt;
                        tx_valid <= 1'b1;
                        tx_data  <= PREAMBLE_BYTE;
                    end
                end
                S_PRE, S_ETH, S_IP, S_UDP, S_PAY, S_FCS: begin
                    tx_valid <= 1'b1;
                    tx_data  <= nb;
                    if (idx == last_idx) begin
                        state <= nxt;
                        idx   <= '0;
                        if (state == S_FCS) pkt_cnt <= pkt_cnt + 16'd1;
                    end
                    // Fold the ID into the constant sum while the MAC header is going out.
                    if (state == S_ETH) begin
                        case (idx)
                            CW'(0):  csum_acc <= CSUM_CONST + 32'(pkt_id);
                            CW'(1),
                            CW'(2):  csum_acc <= 32'(csum_acc[15:0]) + 32'(csum_acc[31:16]);
                            CW'(3):  ip_csum  <= ~csum_acc[15:0];
                            default: ;
                        endcase
                    end
                end
                S_IFG: begin
                    if (idx == CW'(IFG_LEN - 1)) begin
                        state <= S_IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    crc32_d8 u_crc (
        .clk  (clk),
        .rstn (rstn),
        .init (crc_init),
        .en   (crc_en),
        .d    (nb),
        .crc  (crc)
    );

endmodule
